// File: rtl/dac_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : dac_frame_sequencer
//  Description : Latches per-channel samples for a 4-channel DAC and feeds
//                24-bit command frames to the SPI serialiser. Channels are
//                serviced round-robin, and frames are spaced by a fixed gap.
//                Optional macro DAC_SYNC_UPDATE_EN: channel writes go to the
//                input registers only, and a broadcast update frame follows
//                each burst.
//  Revision    : 1.0 - initial release
// ============================================================================
module dac_frame_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int SEND_GAP   = 256
) (
    input  logic                  clock_in,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] sample_in,
    input  logic [1:0]            channel_in,
    input  logic                  sample_valid,
    output logic [23:0]           dac_data,
    output logic                  dac_send,
    output logic                  busy,
    output logic                  overrun
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    localparam int                 c_GAP_W    = (SEND_GAP > 2) ? $clog2(SEND_GAP) : 1;
    localparam logic [c_GAP_W-1:0] c_GAP_LOAD = c_GAP_W'((SEND_GAP > 0) ? SEND_GAP - 1 : 0);

`ifdef DAC_SYNC_UPDATE_EN
    localparam logic [3:0]  c_CMD_CH       = 4'b0001;
    localparam logic [23:0] c_UPDATE_FRAME = {4'b0010, 4'b1111, 16'h0000};
`else
    localparam logic [3:0]  c_CMD_CH       = 4'b0011;
`endif

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_GAP_W-1:0] r_gap_cnt;
    logic [15:0]        r_value [4];
    logic [3:0]         r_pending;
    logic [1:0]         r_last_ch;
    logic [23:0]        r_dac_data;
    logic               r_overrun;

    logic               w_sel_found;
    logic [1:0]         w_sel_ch;
    logic [3:0]         w_sel_onehot;
    logic               w_load_ch;
    logic [3:0]         w_clear_mask;
    logic [3:0]         w_set_mask;
    logic [15:0]        w_sample_ext;

`ifdef DAC_SYNC_UPDATE_EN
    logic               r_update_due;
    logic               w_load_upd;
`endif

    assign w_sample_ext = 16'(sample_in) << (16 - DATA_WIDTH);

    // Scan starts one past the last granted channel so no channel can starve.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_ch    = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            if (!w_sel_found && r_pending[r_last_ch + 2'(i)]) begin
                w_sel_found = 1'b1;
                w_sel_ch    = r_last_ch + 2'(i);
            end
        end
    end

    assign w_sel_onehot = 4'b0001 << w_sel_ch;
    assign w_clear_mask = w_load_ch ? w_sel_onehot : 4'b0000;
    assign w_set_mask   = sample_valid ? (4'b0001 << channel_in) : 4'b0000;

    always_comb begin
        w_state_nxt = r_state;
        w_load_ch   = 1'b0;
`ifdef DAC_SYNC_UPDATE_EN
        w_load_upd  = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_sel_found) begin
                    w_load_ch   = 1'b1;
                    w_state_nxt = S_SEND;
                end
`ifdef DAC_SYNC_UPDATE_EN
                else if (r_update_due) begin
                    w_load_upd  = 1'b1;
                    w_state_nxt = S_SEND;
                end
`endif
            end
            S_SEND:  w_state_nxt = S_GAP;
            S_GAP: begin
                if (r_gap_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_gap_cnt <= '0;
        end else if (r_state == S_SEND) begin
            r_gap_cnt <= c_GAP_LOAD;
        end else if (r_state == S_GAP && r_gap_cnt != '0) begin
            r_gap_cnt <= r_gap_cnt - 1'b1;
        end
    end

    // A capture on the channel being granted keeps it pending: the new value
    // arrives after the old one was already copied into the frame.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_pending <= 4'b0000;
            r_overrun <= 1'b0;
            r_last_ch <= 2'd3;
            for (int i = 0; i < 4; i++) begin
                r_value[i] <= '0;
            end
        end else begin
            r_pending <= (r_pending & ~w_clear_mask) | w_set_mask;
            r_overrun <= |(r_pending & ~w_clear_mask & w_set_mask);
            if (sample_valid) begin
                r_value[channel_in] <= w_sample_ext;
            end
            if (w_load_ch) begin
                r_last_ch <= w_sel_ch;
            end
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_dac_data <= 24'h000000;
        end else if (w_load_ch) begin
            r_dac_data <= {c_CMD_CH, w_sel_onehot, r_value[w_sel_ch]};
        end
`ifdef DAC_SYNC_UPDATE_EN
        else if (w_load_upd) begin
            r_dac_data <= c_UPDATE_FRAME;
        end
`endif
    end

`ifdef DAC_SYNC_UPDATE_EN
    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_update_due <= 1'b0;
        end else if (w_load_ch) begin
            r_update_due <= 1'b1;
        end else if (w_load_upd) begin
            r_update_due <= 1'b0;
        end
    end
`endif

    assign dac_data = r_dac_data;
    assign dac_send = (r_state == S_SEND);
    assign busy     = (r_state != S_IDLE) || (|r_pending);
    assign overrun  = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_dac_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dac_frame_sequencer
//  Description : Self-checking bench for dac_frame_sequencer. A timeline
//                reference model (pending set, grant pointer, next-free edge)
//                predicts every output after every clock edge.
//                Honours DAC_SYNC_UPDATE_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dac_frame_sequencer;

    localparam int GAP = 8;
`ifdef DAC_SYNC_UPDATE_EN
    localparam bit         c_SYNC = 1'b1;
    localparam logic [3:0] c_CMD  = 4'h1;
`else
    localparam bit         c_SYNC = 1'b0;
    localparam logic [3:0] c_CMD  = 4'h3;
`endif

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        r_reset;
    logic        r_valid;
    logic [1:0]  r_ch;
    logic [15:0] r_sample;
    logic [23:0] w_dac_data;
    logic        w_dac_send;
    logic        w_busy;
    logic        w_overrun;

    logic        r_reset12;
    logic        r_valid12;
    logic [1:0]  r_ch12;
    logic [11:0] r_sample12;
    logic [23:0] w_dac_data12;
    logic        w_dac_send12;
    logic        w_busy12;
    logic        w_overrun12;

    dac_frame_sequencer #(.DATA_WIDTH(16), .SEND_GAP(GAP)) u_dut (
        .clock_in     (clk),
        .reset        (r_reset),
        .sample_in    (r_sample),
        .channel_in   (r_ch),
        .sample_valid (r_valid),
        .dac_data     (w_dac_data),
        .dac_send     (w_dac_send),
        .busy         (w_busy),
        .overrun      (w_overrun)
    );

    dac_frame_sequencer #(.DATA_WIDTH(12), .SEND_GAP(GAP)) u_dut12 (
        .clock_in     (clk),
        .reset        (r_reset12),
        .sample_in    (r_sample12),
        .channel_in   (r_ch12),
        .sample_valid (r_valid12),
        .dac_data     (w_dac_data12),
        .dac_send     (w_dac_send12),
        .busy         (w_busy12),
        .overrun      (w_overrun12)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s @edge %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // Reference model: state is the pending set, stored values, grant
    // pointer and the first edge at which a new grant is allowed.
    int          cyc = 0;
    logic [15:0] m_val [4];
    logic [3:0]  m_pend;
    int          m_last;
    int          m_next_pick;
    int          m_pick_edge;
    logic [23:0] m_data;
    logic        m_ovr;
    logic        m_upd_due;

    task automatic model_edge();
        int pick;
        bit start;
        if (r_reset) begin
            for (int i = 0; i < 4; i++) m_val[i] = 16'h0;
            m_pend      = 4'h0;
            m_last      = 3;
            m_next_pick = 0;
            m_pick_edge = -1;
            m_data      = 24'h0;
            m_ovr       = 1'b0;
            m_upd_due   = 1'b0;
        end else begin
            pick  = -1;
            start = 1'b0;
            if (cyc >= m_next_pick) begin
                for (int i = 1; i <= 4; i++) begin
                    if (pick < 0 && m_pend[(m_last + i) % 4]) pick = (m_last + i) % 4;
                end
                if (pick >= 0) begin
                    m_data       = {c_CMD, 4'(1 << pick), m_val[pick]};
                    m_pend[pick] = 1'b0;
                    m_last       = pick;
                    m_upd_due    = 1'b1;
                    start        = 1'b1;
                end else if (c_SYNC && m_upd_due) begin
                    m_data    = 24'h2F0000;
                    m_upd_due = 1'b0;
                    start     = 1'b1;
                end
                if (start) begin
                    m_pick_edge = cyc;
                    m_next_pick = cyc + GAP + 2;
                end
            end
            m_ovr = 1'b0;
            if (r_valid) begin
                m_ovr         = m_pend[r_ch];
                m_val[r_ch]   = r_sample;
                m_pend[r_ch]  = 1'b1;
            end
        end
    endtask

    task automatic step(input logic rst, input logic v, input logic [1:0] ch, input logic [15:0] s);
        r_reset  = rst;
        r_valid  = v;
        r_ch     = ch;
        r_sample = s;
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        check("dac_data", 32'(w_dac_data), 32'(m_data));
        check("dac_send", 32'(w_dac_send), 32'(cyc == m_pick_edge));
        check("busy",     32'(w_busy),     32'((cyc < m_next_pick - 1) || (|m_pend)));
        check("overrun",  32'(w_overrun),  32'(m_ovr));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'd0, 16'h0);
    endtask

    initial begin
        r_reset12  = 1'b1;
        r_valid12  = 1'b0;
        r_ch12     = 2'd0;
        r_sample12 = 12'h0;

        step(1'b1, 1'b0, 2'd0, 16'h0);
        step(1'b1, 1'b0, 2'd0, 16'h0);
        r_reset12 = 1'b0;
        check("reset_data", 32'(w_dac_data), 32'h0);
        check("reset_busy", 32'(w_busy), 32'h0);

        // Single sample on channel 0
        step(1'b0, 1'b1, 2'd0, 16'hB155);
        check("t1_no_early_send", 32'(w_dac_send), 32'h0);
        idle(1);
        check("t1_data", 32'(w_dac_data), 32'({c_CMD, 20'h1B155}));
        check("t1_send", 32'(w_dac_send), 32'h1);
        idle(GAP + 1);
        check("t1_busy_clear", 32'(w_busy), 32'h0);
        idle(2 * GAP + 6);

        // Three channels back to back: round-robin order and spacing
        step(1'b0, 1'b1, 2'd2, 16'h1111);
        step(1'b0, 1'b1, 2'd0, 16'h2222);
        step(1'b0, 1'b1, 2'd3, 16'h3333);
        idle(5 * GAP + 12);

        // Overwrite before service
        step(1'b0, 1'b1, 2'd2, 16'h0F0F);
        step(1'b0, 1'b1, 2'd1, 16'hAAAA);
        step(1'b0, 1'b1, 2'd1, 16'h5555);
        check("t3_overrun", 32'(w_overrun), 32'h1);
        idle(4 * GAP + 10);

        // 12-bit instance: left justification
        r_ch12     = 2'd2;
        r_sample12 = 12'hABC;
        r_valid12  = 1'b1;
        @(posedge clk);
        #1;
        r_valid12  = 1'b0;
        @(posedge clk);
        #1;
        check("dw12_data", 32'(w_dac_data12), 32'({c_CMD, 4'b0100, 16'hABC0}));
        check("dw12_send", 32'(w_dac_send12), 32'h1);
        // keep the main model in step with the two raw edges above
        cyc = cyc + 2;
        m_next_pick = m_next_pick;

        // Reset during the gap
        idle(2 * GAP + 6);
        step(1'b0, 1'b1, 2'd3, 16'h7777);
        step(1'b0, 1'b1, 2'd1, 16'h1234);
        idle(3);
        step(1'b1, 1'b0, 2'd0, 16'h0);
        check("t5_data", 32'(w_dac_data), 32'h0);
        check("t5_busy", 32'(w_busy), 32'h0);
        idle(2 * GAP + 6);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 4000; i++) begin
            logic rst;
            logic v;
            rst = ($urandom_range(0, 999) < 3);
            v   = (i < 2000) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 0);
            step(rst, v, 2'($urandom_range(0, 3)), 16'($urandom));
        end
        idle(6 * GAP + 12);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
